// File: rtl/mac_filter_pkg.sv
// rtl/mac_filter_pkg.sv - header parser states, descriptor type and constants (optional VLAN parsing: MAC_HDR_VLAN_EN)
package mac_filter_pkg;

    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    // One state per header beat; W4 is only reachable when VLAN parsing is built in
    typedef enum logic [2:0] {
        ST_W0   = 3'd0,
        ST_W1   = 3'd1,
        ST_W2   = 3'd2,
        ST_W3   = 3'd3,
        ST_W4   = 3'd4,
        ST_BODY = 3'd5
    } hdr_state_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ethertype;
        logic        runt;
        logic        vlan_valid;
        logic [11:0] vlan_id;
    } hdr_desc_t;

    // Frame byte 0 travels in tdata[7:0]; return the beat with the first wire byte in [31:24]
    function automatic logic [31:0] wire_order(input logic [31:0] tdata);
        return {tdata[7:0], tdata[15:8], tdata[23:16], tdata[31:24]};
    endfunction

endpackage

// File: rtl/mac_hdr_extract_if.sv
// rtl/mac_hdr_extract_if.sv - AXI-Stream style frame bus with master/slave views
interface mac_hdr_extract_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/mac_hdr_skid.sv
// rtl/mac_hdr_skid.sv - one-deep register slice on the frame path with an external stall
module mac_hdr_skid #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    mac_hdr_extract_if.slave   s,
    mac_hdr_extract_if.master  m,
    output logic               s_accept
);

    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] keep_q, keep_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                s_ready;

    // Accept when the output slot is free or draining this cycle, unless the parser holds us off
    always_comb begin
        s_ready  = !rst && (!valid_q || m.tready) && !stall;
        s_accept = s.tvalid && s_ready;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        valid_d  = valid_q;
        if (s_accept) begin
            valid_d = 1'b1;
            data_d  = s.tdata;
            keep_d  = s.tkeep;
            last_d  = s.tlast;
        end else if (m.tready) begin
            valid_d = 1'b0;
        end
    end

    // Output slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign s.tready = s_ready;
    assign m.tdata  = data_q;
    assign m.tkeep  = keep_q;
    assign m.tlast  = last_q;
    assign m.tvalid = valid_q;

endmodule

// File: rtl/mac_hdr_extract.sv
// rtl/mac_hdr_extract.sv - Ethernet header parser with pass-through stream (optional 802.1Q parsing: MAC_HDR_VLAN_EN)
module mac_hdr_extract
    import mac_filter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               ACLK,
    input  logic               ARESET,
    mac_hdr_extract_if.slave   s_axis,
    mac_hdr_extract_if.master  m_axis,
    output logic               hdr_valid,
    input  logic               hdr_ready,
    output logic [47:0]        hdr_dst_mac,
    output logic [47:0]        hdr_src_mac,
    output logic [15:0]        hdr_ethertype,
    output logic               hdr_runt,
    output logic               hdr_vlan_valid,
    output logic [11:0]        hdr_vlan_id,
    output logic [31:0]        stat_frames,
    output logic [15:0]        stat_runts
);

    hdr_state_t  state_q, state_d;
    hdr_desc_t   work_q, work_d;
    hdr_desc_t   desc_q, desc_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [31:0] frames_q, frames_d;
    logic [15:0] runts_q, runts_d;

    logic [31:0] beat;
    logic        vlan_tag;
    logic        hdr_done;
    logic        hdr_stall;
    logic        s_accept;

    mac_hdr_skid #(.DATA_W(DATA_W)) u_skid (
        .clk      (ACLK),
        .rst      (ARESET),
        .stall    (hdr_stall),
        .s        (s_axis),
        .m        (m_axis),
        .s_accept (s_accept)
    );

    // Decide whether the offered beat would finish a descriptor; hold it off while the old one is unconsumed
    always_comb begin
        beat = wire_order(s_axis.tdata);
`ifdef MAC_HDR_VLAN_EN
        vlan_tag = (state_q == ST_W3) && (beat[31:16] == ETH_TYPE_VLAN);
        hdr_done = (state_q != ST_BODY) &&
                   (s_axis.tlast || (state_q == ST_W4) || ((state_q == ST_W3) && !vlan_tag));
`else
        vlan_tag = 1'b0;
        hdr_done = (state_q != ST_BODY) && (s_axis.tlast || (state_q == ST_W3));
`endif
        hdr_stall = hdr_valid_q && !hdr_ready && hdr_done;
    end

    // Header capture, descriptor hand-off and statistics for each accepted beat
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        desc_d      = desc_q;
        hdr_valid_d = hdr_valid_q;
        frames_d    = frames_q;
        runts_d     = runts_q;

        if (hdr_valid_q && hdr_ready) begin
            hdr_valid_d = 1'b0;
        end

        if (s_accept) begin
            case (state_q)
                ST_W0: begin
                    work_d.dst[47:16] = beat;
                    state_d           = ST_W1;
                end
                ST_W1: begin
                    work_d.dst[15:0]  = beat[31:16];
                    work_d.src[47:32] = beat[15:0];
                    state_d           = ST_W2;
                end
                ST_W2: begin
                    work_d.src[31:0] = beat;
                    state_d          = ST_W3;
                end
                ST_W3: begin
                    if (vlan_tag) begin
                        work_d.vlan_valid = 1'b1;
                        work_d.vlan_id    = beat[11:0];
                        state_d           = ST_W4;
                    end else begin
                        work_d.ethertype = beat[31:16];
                        state_d          = ST_BODY;
                    end
                end
                ST_W4: begin
                    work_d.ethertype = beat[31:16];
                    state_d          = ST_BODY;
                end
                default: begin
                    state_d = ST_BODY;
                end
            endcase

            // A frame ending inside the header still yields a descriptor, flagged as runt
            if (hdr_done) begin
                desc_d      = work_d;
                desc_d.runt = s_axis.tlast;
                hdr_valid_d = 1'b1;
                frames_d    = frames_q + 32'd1;
                if (s_axis.tlast && (runts_q != 16'hFFFF)) begin
                    runts_d = runts_q + 16'd1;
                end
            end

            if (hdr_done || s_axis.tlast) begin
                work_d = '0;
            end
            if (s_axis.tlast) begin
                state_d = ST_W0;
            end
        end
    end

    // Parser state, descriptor and counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_W0;
            work_q      <= '0;
            desc_q      <= '0;
            hdr_valid_q <= 1'b0;
            frames_q    <= '0;
            runts_q     <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            desc_q      <= desc_d;
            hdr_valid_q <= hdr_valid_d;
            frames_q    <= frames_d;
            runts_q     <= runts_d;
        end
    end

    // VLAN fields are only ever written when tag detection is built in, so they read 0 otherwise
    assign hdr_valid      = hdr_valid_q;
    assign hdr_dst_mac    = desc_q.dst;
    assign hdr_src_mac    = desc_q.src;
    assign hdr_ethertype  = desc_q.ethertype;
    assign hdr_runt       = desc_q.runt;
    assign hdr_vlan_valid = desc_q.vlan_valid;
    assign hdr_vlan_id    = desc_q.vlan_id;
    assign stat_frames    = frames_q;
    assign stat_runts     = runts_q;

endmodule

// File: tb/tb_mac_hdr_extract.sv
// tb/tb_mac_hdr_extract.sv - directed and randomised-backpressure bench for mac_hdr_extract
`timescale 1ns/1ps
module tb_mac_hdr_extract;

`ifdef MAC_HDR_VLAN_EN
    localparam bit VLAN_EN = 1'b1;
`else
    localparam bit VLAN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic        runt;
        logic        vv;
        logic [11:0] vid;
    } exp_t;

    logic        clk = 1'b0;
    logic        areset;
    logic        hdr_valid, hdr_ready;
    logic [47:0] dst, src;
    logic [15:0] et;
    logic        runt, vv;
    logic [11:0] vid;
    logic [31:0] stat_frames;
    logic [15:0] stat_runts;

    mac_hdr_extract_if s_if ();
    mac_hdr_extract_if m_if ();

    mac_hdr_extract dut (
        .ACLK           (clk),
        .ARESET         (areset),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_dst_mac    (dst),
        .hdr_src_mac    (src),
        .hdr_ethertype  (et),
        .hdr_runt       (runt),
        .hdr_vlan_valid (vv),
        .hdr_vlan_id    (vid),
        .stat_frames    (stat_frames),
        .stat_runts     (stat_runts)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          rnd_mode = 1'b0;
    int          out_beats = 0;
    int          desc_count = 0;
    int          cur_frame = 0;
    int          cur_beat = 0;
    int          exp_frames = 0;
    int          exp_runts = 0;
    logic [7:0]  fb [0:255];
    exp_t        dq [$];
    logic [36:0] oq [$];
    exp_t        last_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected descriptor from the frame bytes: bytes of any beat that was sent are visible, the rest read 0
    function automatic void push_model(input int len);
        int nb = (len + 3) / 4;
        int avail = nb * 4;
        logic [7:0] b [0:19];
        exp_t e;
        for (int i = 0; i < 20; i++) b[i] = (i < avail) ? fb[i] : 8'h00;
        e = '0;
        e.dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
        e.src = {b[6], b[7], b[8], b[9], b[10], b[11]};
        if (VLAN_EN && nb >= 4 && {b[12], b[13]} == 16'h8100) begin
            e.vv   = 1'b1;
            e.vid  = {b[14][3:0], b[15]};
            e.et   = {b[16], b[17]};
            e.runt = (nb <= 5);
        end else begin
            e.et   = {b[12], b[13]};
            e.runt = (nb <= 4);
        end
        dq.push_back(e);
        exp_frames++;
        if (e.runt && exp_runts < 65535) exp_runts++;
    endfunction

    function automatic void build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        for (int i = 0; i < 256; i++) fb[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 6; i++) begin
            fb[i]     = d[47 - 8*i -: 8];
            fb[6 + i] = s[47 - 8*i -: 8];
        end
        fb[12] = t[15:8];
        fb[13] = t[7:0];
    endfunction

    function automatic logic [31:0] beat_word(input int b);
        return {fb[4*b+3], fb[4*b+2], fb[4*b+1], fb[4*b]};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!s_if.tready) chk("beat_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input int fidx);
        int nb = (len + 3) / 4;
        push_model(len);
        for (int b = 0; b < nb; b++) begin
            int rem = len - 4*b;
            logic [3:0] k;
            logic l;
            k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            l = (b == nb - 1);
            oq.push_back({beat_word(b), k, l});
            cur_frame = fidx;
            cur_beat  = b;
            drive_beat(beat_word(b), k, l);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((dq.size() != 0 || oq.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(dq.size() + oq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_s_tready"}, 64'(s_if.tready), 64'd0);
        chk({p, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
        chk({p, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
        chk({p, "_runt"}, 64'(runt), 64'd0);
        chk({p, "_vlan_valid"}, 64'(vv), 64'd0);
        chk({p, "_vlan_id"}, 64'(vid), 64'd0);
        chk({p, "_dst"}, 64'(dst), 64'd0);
        chk({p, "_src"}, 64'(src), 64'd0);
        chk({p, "_ethertype"}, 64'(et), 64'd0);
        chk({p, "_stat_frames"}, 64'(stat_frames), 64'd0);
        chk({p, "_stat_runts"}, 64'(stat_runts), 64'd0);
    endtask

    // Compare process: output beats against the stream scoreboard, descriptor fields against the model
    always @(negedge clk) begin
        if (chk_en && !areset) begin
            if (m_if.tvalid && m_if.tready) begin
                if (oq.size() == 0) begin
                    chk("out_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk("out_beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'(oq[0]));
                    void'(oq.pop_front());
                    out_beats++;
                end
            end
            if (hdr_valid) begin
                if (dq.size() == 0) begin
                    chk("hdr_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("hdr_dst", 64'(dst), 64'(dq[0].dst));
                    chk("hdr_src", 64'(src), 64'(dq[0].src));
                    chk("hdr_ethertype", 64'(et), 64'(dq[0].et));
                    chk("hdr_runt", 64'(runt), 64'(dq[0].runt));
                    chk("hdr_vlan_valid", 64'(vv), 64'(dq[0].vv));
                    chk("hdr_vlan_id", 64'(vid), 64'(dq[0].vid));
                    if (hdr_ready) begin
                        last_d = '{dst: dst, src: src, et: et, runt: runt, vv: vv, vid: vid};
                        void'(dq.pop_front());
                        desc_count++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                m_if.tready = 1'($urandom_range(0, 1));
                hdr_ready   = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, total_beats, len;
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        hdr_ready   = 1'b1;
        last_d      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        sync();
        areset = 1'b0;
        chk_en = 1'b1;

        // 64-byte frame with fixed addresses
        build_frame(48'h020000000001, 48'h020000000002, 16'h0800);
        out_beats = 0;
        send_frame(64, 0);
        wait_drain("drain_basic");
        chk("basic_dst", 64'(last_d.dst), 64'h020000000001);
        chk("basic_src", 64'(last_d.src), 64'h020000000002);
        chk("basic_ethertype", 64'(last_d.et), 64'h0800);
        chk("basic_runt", 64'(last_d.runt), 64'd0);
        chk("basic_stat_frames", 64'(stat_frames), 64'd1);
        chk("basic_out_beats", 64'(out_beats), 64'd16);

        // 8-byte runt, bytes 6..7 zero so the whole source field reads 0
        build_frame(48'h020000000003, 48'h0, 16'h0);
        sync();
        send_frame(8, 0);
        wait_drain("drain_runt");
        chk("runt_flag", 64'(last_d.runt), 64'd1);
        chk("runt_dst", 64'(last_d.dst), 64'h020000000003);
        chk("runt_src", 64'(last_d.src), 64'd0);
        chk("runt_ethertype", 64'(last_d.et), 64'd0);
        chk("runt_stat_runts", 64'(stat_runts), 64'd1);
        chk("runt_stat_frames", 64'(stat_frames), 64'd2);

        // Back-to-back full-rate: two 20-byte frames then four single-beat runts
        sync();
        t0 = cyc;
        build_frame(48'h0A0B0C0D0E0F, 48'h111213141516, 16'h0806);
        send_frame(20, 0);
        build_frame(48'h212223242526, 48'h313233343536, 16'h88CC);
        send_frame(20, 1);
        for (int i = 0; i < 4; i++) begin
            build_frame(48'hA0A1A2A3A4A5 + 48'(i), 48'h0, 16'h0);
            send_frame(4, 2 + i);
        end
        chk("b2b_cycles", 64'(cyc - t0), 64'd14);
        wait_drain("drain_b2b");
        chk("b2b_stat_frames", 64'(stat_frames), 64'(exp_frames));
        chk("b2b_stat_runts", 64'(stat_runts), 64'd5);

        // Descriptor held unconsumed: second frame must stall on its fourth beat
        sync();
        hdr_ready = 1'b0;
        d0 = desc_count;
        fork
            begin
                build_frame(48'h020000000011, 48'h020000000012, 16'h0800);
                send_frame(24, 0);
                build_frame(48'h020000000021, 48'h020000000022, 16'h86DD);
                send_frame(24, 1);
            end
            begin
                int n = 0;
                while (!hdr_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_first_desc_seen", 64'(hdr_valid), 64'd1);
                repeat (20) @(negedge clk);
                chk("stall_s_tvalid", 64'(s_if.tvalid), 64'd1);
                chk("stall_s_tready", 64'(s_if.tready), 64'd0);
                chk("stall_frame_idx", 64'(cur_frame), 64'd1);
                chk("stall_beat_idx", 64'(cur_beat), 64'd3);
                sync();
                hdr_ready = 1'b1;
            end
        join
        wait_drain("drain_stall");
        chk("stall_desc_count", 64'(desc_count - d0), 64'd2);
        chk("stall_stat_frames", 64'(stat_frames), 64'(exp_frames));

        // 802.1Q tagged frame
        build_frame(48'h020000000031, 48'h020000000032, 16'h8100);
        fb[14] = 8'h01;
        fb[15] = 8'h23;
        fb[16] = 8'h86;
        fb[17] = 8'hDD;
        sync();
        send_frame(64, 0);
        wait_drain("drain_vlan");
`ifdef MAC_HDR_VLAN_EN
        chk("vlan_valid", 64'(last_d.vv), 64'd1);
        chk("vlan_id", 64'(last_d.vid), 64'h123);
        chk("vlan_ethertype", 64'(last_d.et), 64'h86DD);
`else
        chk("vlan_valid", 64'(last_d.vv), 64'd0);
        chk("vlan_id", 64'(last_d.vid), 64'd0);
        chk("vlan_ethertype", 64'(last_d.et), 64'h8100);
`endif

        // 100 frames with random backpressure on both outputs
        out_beats   = 0;
        total_beats = 0;
        sync();
        rnd_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
            len = $urandom_range(1, 64);
            total_beats += (len + 3) / 4;
            send_frame(len, f);
        end
        wait_drain("drain_random");
        rnd_mode = 1'b0;
        @(posedge clk);
        #2;
        m_if.tready = 1'b1;
        hdr_ready   = 1'b1;
        chk("random_out_beats", 64'(out_beats), 64'(total_beats));
        chk("random_stat_frames", 64'(stat_frames), 64'(exp_frames));
        chk("random_stat_runts", 64'(stat_runts), 64'(exp_runts));

        // Reset while the third beat of a frame is offered
        build_frame(48'h020000000001, 48'h020000000002, 16'h0800);
        sync();
        chk_en = 1'b0;
        drive_beat(beat_word(0), 4'hF, 1'b0);
        drive_beat(beat_word(1), 4'hF, 1'b0);
        s_if.tdata  = beat_word(2);
        s_if.tkeep  = 4'hF;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        areset      = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        sync();
        areset      = 1'b0;
        s_if.tvalid = 1'b0;
        dq.delete();
        oq.delete();
        exp_frames = 0;
        exp_runts  = 0;
        chk_en     = 1'b1;
        sync();
        send_frame(64, 0);
        wait_drain("drain_after_reset");
        chk("post_reset_dst", 64'(last_d.dst), 64'h020000000001);
        chk("post_reset_ethertype", 64'(last_d.et), 64'h0800);
        chk("post_reset_stat_frames", 64'(stat_frames), 64'd1);
        chk("post_reset_stat_runts", 64'(stat_runts), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
